pipeline_control_unit: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Combines load-use hazard

---
 rtl/pipeline_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - stall/flush sequencer for a 5-stage RV32I pipeline
//
// Purpose:
//   Combines load-use hazard detection, EX-stage redirects and the multi-cycle
//   data-memory handshake into per-stage register enables and flushes.
//   All control outputs are combinational from the current state and inputs.
//   Optional feature macro: PIPE_PERF_COUNTERS_EN builds the stall/flush
//   performance counters; without it both counts are tied to zero.
//
// Ports:
//   clk, reset                         clock (rising edge), async active-high reset
//   ID_Rs1_address/ID_Rs2_address      source registers of the instruction in ID
//   ID_Rs1_used/ID_Rs2_used            ID instruction actually reads rs1/rs2
//   EX_Mem_rd_en, EX_Rd_address        EX instruction is a load, and its rd
//   EX_Branch_taken                    EX redirects the PC
//   MEM_Dmem_req, MEM_Dmem_ready       data-memory access request / completion
//   PC_en .. MEM_WB_en                 stage register enables
//   IF_ID_flush, ID_EX_flush,
//   MEM_WB_flush                       load a bubble into the stage register
//   Mem_timeout                        sticky: memory wait exceeded MEM_TIMEOUT
//   Stall_count, Flush_count           perf counts of PC_en=0 / IF_ID_flush=1 cycles
module pipeline_control_unit #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int INIT_CYCLES        = 5,
  parameter int MEM_TIMEOUT        = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_address,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_address,
  input  logic                          ID_Rs1_used,
  input  logic                          ID_Rs2_used,
  input  logic                          EX_Mem_rd_en,
  input  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_address,
  input  logic                          EX_Branch_taken,
  input  logic                          MEM_Dmem_req,
  input  logic                          MEM_Dmem_ready,
  output logic                          PC_en,
  output logic                          IF_ID_en,
  output logic                          ID_EX_en,
  output logic                          EX_MEM_en,
  output logic                          MEM_WB_en,
  output logic                          IF_ID_flush,
  output logic                          ID_EX_flush,
  output logic                          MEM_WB_flush,
  output logic                          Mem_timeout,
  output logic [31:0]                   Stall_count,
  output logic [31:0]                   Flush_count
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_WAIT} state_t;

  localparam logic [15:0] INIT_LAST   = 16'(INIT_CYCLES - 1);
  localparam logic [7:0]  TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] init_cnt_q, init_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;
  logic        lu_block_q, lu_block_d;

  logic load_use;
  logic wait_cond;
  logic hold;
  logic resolve;
  logic lu_stall;

  // Hazard decode shared by the next-state and output processes.
  // "resolve" is a cycle where the normal RUN priority applies: RUN without a
  // new memory wait, or the completing cycle of a memory wait.
  // lu_block_q suppresses a second stall if the load-use pattern is still
  // present in the cycle right after a load-use stall.
  always_comb begin
    load_use  = EX_Mem_rd_en && (EX_Rd_address != '0) &&
                ((ID_Rs1_used && (ID_Rs1_address == EX_Rd_address)) ||
                 (ID_Rs2_used && (ID_Rs2_address == EX_Rd_address)));
    wait_cond = MEM_Dmem_req && !MEM_Dmem_ready;
    hold      = ((state_q == ST_RUN) && wait_cond) ||
                ((state_q == ST_WAIT) && !MEM_Dmem_ready);
    resolve   = ((state_q == ST_RUN) && !wait_cond) ||
                ((state_q == ST_WAIT) && MEM_Dmem_ready);
    lu_stall  = resolve && !EX_Branch_taken && load_use && !lu_block_q;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
      lu_block_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
      lu_block_q <= lu_block_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    to_cnt_d   = to_cnt_q;
    lu_block_d = lu_stall;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
        else                         init_cnt_d = init_cnt_q + 16'd1;
      end
      ST_RUN: begin
        if (wait_cond) begin
          state_d  = ST_WAIT;
          to_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
        if (MEM_Dmem_ready)    state_d  = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
    // Flag rises on the edge where the wait count reaches the limit.
    timeout_d = timeout_q || ((state_q == ST_WAIT) && (to_cnt_d == TIMEOUT_VAL));
  end

  // Output logic
  always_comb begin
    PC_en        = 1'b1;
    IF_ID_en     = 1'b1;
    ID_EX_en     = 1'b1;
    EX_MEM_en    = 1'b1;
    MEM_WB_en    = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    MEM_WB_flush = 1'b0;
    if (state_q == ST_INIT) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (hold) begin
      // Freeze the pipe; MEM/WB keeps clocking in bubbles so WB retires nothing.
      PC_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EX_en     = 1'b0;
      EX_MEM_en    = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (resolve && EX_Branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (lu_stall) begin
      PC_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  assign Mem_timeout = timeout_q;

`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != ST_INIT) begin
      if (!PC_en)      stall_cnt_d = stall_cnt_q + 32'd1;
      if (IF_ID_flush) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_count = stall_cnt_q;
  assign Flush_count = flush_cnt_q;
`else
  assign Stall_count = 32'd0;
  assign Flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - scoreboard bench for pipeline_control_unit
module tb_pipeline_control_unit;

`ifdef PIPE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB enables, IF_ID,ID_EX,MEM_WB flushes, Mem_timeout}
  localparam logic [8:0] E_INIT = 9'b11111_111_0;
  localparam logic [8:0] E_RUN  = 9'b11111_000_0;
  localparam logic [8:0] E_LU   = 9'b00111_010_0;
  localparam logic [8:0] E_BR   = 9'b11111_110_0;
  localparam logic [8:0] E_WT   = 9'b00001_001_0;
  localparam logic [8:0] E_WT1  = 9'b00001_001_1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        u1 = 0, u2 = 0, ld = 0, br = 0, req = 0, rdy = 0;
  logic        PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic        IF_ID_flush, ID_EX_flush, MEM_WB_flush, Mem_timeout;
  logic [31:0] Stall_count, Flush_count;

  pipeline_control_unit #(.REGFILE_ADDR_WIDTH(5), .INIT_CYCLES(5), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs1_address(rs1), .ID_Rs2_address(rs2),
    .ID_Rs1_used(u1), .ID_Rs2_used(u2),
    .EX_Mem_rd_en(ld), .EX_Rd_address(rd), .EX_Branch_taken(br),
    .MEM_Dmem_req(req), .MEM_Dmem_ready(rdy),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .MEM_WB_flush(MEM_WB_flush),
    .Mem_timeout(Mem_timeout), .Stall_count(Stall_count), .Flush_count(Flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [8:0]  ctl;
    bit          cc;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  // Monitor: every cycle is an output beat; compare mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if ({PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
           IF_ID_flush, ID_EX_flush, MEM_WB_flush, Mem_timeout} !== e.ctl) begin
        bad++;
        $display("FAIL %s ctl: got %b want %b", e.nm,
                 {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
                  IF_ID_flush, ID_EX_flush, MEM_WB_flush, Mem_timeout}, e.ctl);
      end
      if (e.cc) begin
        total++;
        if (Stall_count !== e.st) begin
          bad++;
          $display("FAIL %s stall_count: got %0d want %0d", e.nm, Stall_count, e.st);
        end
        total++;
        if (Flush_count !== e.fl) begin
          bad++;
          $display("FAIL %s flush_count: got %0d want %0d", e.nm, Flush_count, e.fl);
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic r,
                     input logic [4:0] a1, input logic iu1,
                     input logic [4:0] a2, input logic iu2,
                     input logic ild, input logic [4:0] ird, input logic ibr,
                     input logic irq, input logic irdy, input logic [8:0] ex,
                     input bit cc = 1'b0, input logic [31:0] es = '0,
                     input logic [31:0] ef = '0);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; rs1 = a1; u1 = iu1; rs2 = a2; u2 = iu2;
    ld = ild; rd = ird; br = ibr; req = irq; rdy = irdy;
    x.nm = nm; x.ctl = ex; x.cc = cc; x.st = es; x.fl = ef;
    sb.push_back(x);
  endtask

  task automatic idle(input string nm, input logic [8:0] ex);
    cyc(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ex);
  endtask

  task automatic reset_and_init();
    cyc("reset", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_INIT,
        1'b1, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++)
      cyc("init", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_INIT,
          1'b1, 32'd0, 32'd0);
    cyc("run_start", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN,
        1'b1, 32'd0, 32'd0);
  endtask

  initial begin
    reset_and_init();
    // load-use on rs1, held two cycles: only the first stalls
    cyc("lu_rs1",  1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_LU);
    cyc("lu_hold", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_RUN);
    idle("lu_after", E_RUN);
    cyc("lu_rs2",  1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_LU);
    idle("lu2_after", E_RUN);
    // no hazard: rd=x0, or matching rs2 not used
    cyc("lu_x0",     1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN);
    cyc("lu_unused", 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_RUN);
    // branch wins over load-use
    cyc("br_lu",     1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_BR);
    idle("br_after", E_RUN);
    // memory wait for three cycles; branch/load-use ignored while waiting
    cyc("wait_1",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_WT);
    cyc("wait_2",  1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_WT);
    cyc("wait_3",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_WT);
    cyc("wait_rdy",1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN);
    // completing cycle resolves load-use as in RUN
    cyc("wait2_1",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_WT);
    cyc("wait2_rdy", 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, E_LU);
    cyc("counts_a",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN,
        1'b1, PERF ? 32'd7 : 32'd0, PERF ? 32'd1 : 32'd0);
    // timeout: ready low 10 cycles, flag set after the 4th MEM_WAIT cycle
    reset_and_init();
    for (int i = 1; i <= 10; i++)
      cyc("to_wait", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
          (i >= 6) ? E_WT1 : E_WT);
    cyc("to_sticky", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_WT1,
        1'b1, PERF ? 32'd10 : 32'd0, 32'd0);
    // async reset mid-wait clears everything
    cyc("rst_mid", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_INIT,
        1'b1, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) idle("reinit", E_INIT);
    idle("rerun", E_RUN);
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
